// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the serial ADC controller.
// Imported by the controller top and its phase-counter sub-module.
package adc_pkg;

    localparam int ADC_DATLEN      = 12;
    localparam int ADC_DATLEN_LOG2 = $clog2(ADC_DATLEN);

    localparam int DEF_LEAD_BITS    = 4;
    localparam int DEF_CLK_DIV      = 2;
    localparam int DEF_QUIET_CYCLES = 8;

    typedef logic [2:0] adc_state_t;

    localparam adc_state_t ST_IDLE    = 3'd0;
    localparam adc_state_t ST_CS_LEAD = 3'd1;
    localparam adc_state_t ST_SCLK_LO = 3'd2;
    localparam adc_state_t ST_SCLK_HI = 3'd3;
    localparam adc_state_t ST_QUIET   = 3'd4;

endpackage

// File: rtl/adc_sclk_phase.sv
// Phase timer: counts cycles spent in the current FSM phase and
// strobes phase_done on the last cycle so the FSM can move on.
module adc_sclk_phase
    import adc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic [W-1:0] len,
    output logic         phase_done
);

    logic [W-1:0] cnt;
    logic [W-1:0] last;

    assign last       = len - W'(1);
    assign phase_done = run && (cnt == last);

    // Restart on every phase boundary; hold at zero while stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || phase_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/adc_serial_ctrl.sv
// Master controller for a 12-bit serial ADC: frames cs_n/sclk,
// shifts in one conversion and offers it on a valid/ready port.
module adc_serial_ctrl
    import adc_pkg::*;
#(
    parameter int LEAD_BITS    = DEF_LEAD_BITS,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    input  logic                  adc_sdata,
    output logic [ADC_DATLEN-1:0] sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun
);

    localparam int N    = LEAD_BITS + ADC_DATLEN;
    localparam int MAXP = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int BW   = $clog2(N + 1);

    localparam logic [PW-1:0] D_LEN    = PW'(CLK_DIV);
    localparam logic [PW-1:0] Q_LEN    = PW'(QUIET_CYCLES);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    adc_state_t            state;
    logic [BW-1:0]         bit_cnt;
    logic [ADC_DATLEN-1:0] shreg;
    logic [PW-1:0]         phase_len;
    logic                  phase_run;
    logic                  phase_done;
    logic                  frame_done;
    logic                  load;

    assign phase_len  = (state == ST_QUIET) ? Q_LEN : D_LEN;
    assign phase_run  = (state != ST_IDLE);
    assign frame_done = (state == ST_SCLK_HI) && phase_done
                        && (bit_cnt == LAST_BIT);
    assign load       = frame_done && (!sample_valid || sample_ready);

    adc_sclk_phase #(
        .W(PW)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (phase_run),
        .len       (phase_len),
        .phase_done(phase_done)
    );

    // Frame sequencer; cs_n and sclk change on the transition edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            bit_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state    <= ST_CS_LEAD;
                        adc_cs_n <= 1'b0;
                    end
                end
                ST_CS_LEAD: begin
                    if (phase_done) begin
                        state    <= ST_SCLK_LO;
                        adc_sclk <= 1'b0;
                    end
                end
                ST_SCLK_LO: begin
                    if (phase_done) begin
                        state    <= ST_SCLK_HI;
                        adc_sclk <= 1'b1;
                    end
                end
                ST_SCLK_HI: begin
                    if (phase_done) begin
                        if (bit_cnt < LAST_BIT) begin
                            bit_cnt  <= bit_cnt + BW'(1);
                            state    <= ST_SCLK_LO;
                            adc_sclk <= 1'b0;
                        end else begin
                            bit_cnt  <= '0;
                            state    <= ST_QUIET;
                            adc_cs_n <= 1'b1;
                        end
                    end
                end
                ST_QUIET: begin
                    if (phase_done) begin
                        if (en) begin
                            state    <= ST_CS_LEAD;
                            adc_cs_n <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b1;
                    bit_cnt  <= '0;
                end
            endcase
        end
    end

    // Capture one data bit on each sclk rising edge; lead bits fall off the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if ((state == ST_SCLK_LO) && phase_done) begin
            shreg <= {shreg[ADC_DATLEN-2:0], adc_sdata};
        end
    end

    // Output handshake: a frame load beats a same-cycle consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= frame_done && !load;
            if (load) begin
                sample       <= shreg;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Self-checking bench for adc_serial_ctrl: ADC bit-stream model,
// frame-timing monitor, handshake reference model and vector table.
module tb_adc_serial_ctrl;
    timeunit 1ns;
    timeprecision 1ps;

    import adc_pkg::*;

    localparam int D   = 2;
    localparam int Q   = 8;
    localparam int LB  = 4;
    localparam int N   = LB + ADC_DATLEN;
    localparam int FL  = D + 2 * D * N;
    localparam int PER = FL + Q;
    localparam int TCK = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        adc_sdata = 1'b0;
    logic        sample_ready = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        overrun;

    always #(TCK / 2) clk = ~clk;

    adc_serial_ctrl #(
        .LEAD_BITS   (LB),
        .CLK_DIV     (D),
        .QUIET_CYCLES(Q)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_sdata   (adc_sdata),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_on = 1'b0;
    bit          check_period = 1'b0;
    bit          prev_fall_ok = 1'b0;
    time         t_fall = 0;
    int          n_falls = 0;
    int          sclk_rises = 0;
    int          rise_base = 0;
    int          bit_idx = 0;
    int          falls0;
    logic [15:0] cur_word = '0;
    logic [15:0] word_q[$];

    typedef struct {
        logic [11:0] data;
        int          mode;
        logic [11:0] exp_sample;
        logic        exp_valid;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    task automatic wait_cs(input logic lvl, input bit rnd);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (rnd) sample_ready = 1'($urandom);
            if (adc_cs_n === lvl) ok = 1'b1;
        end
        if (!ok) fail_now("cs_wait");
    endtask

    task automatic wait_rises(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (sclk_rises - rise_base >= n) ok = 1'b1;
        end
        if (!ok) fail_now("sclk_wait");
    endtask

    // ADC model: new frame word on cs_n fall, next bit after each sclk fall.
    always @(negedge adc_cs_n) begin
        if (word_q.size() > 0) cur_word = word_q.pop_front();
        else cur_word = 16'($urandom);
        bit_idx = N;
        if (mon_on && check_period && prev_fall_ok)
            check("frame_period", 32'((($time - t_fall) / TCK)), PER);
        prev_fall_ok = check_period;
        t_fall = $time;
        rise_base = sclk_rises;
        n_falls++;
    end

    always @(negedge adc_sclk) begin
        if (adc_cs_n == 1'b0 && bit_idx > 0) begin
            bit_idx--;
            adc_sdata = cur_word[bit_idx];
        end
    end

    always @(posedge adc_sclk) begin
        if (adc_cs_n == 1'b0) sclk_rises++;
    end

    // Frame shape: cs_n low time and number of sclk rises per frame.
    always @(posedge adc_cs_n) begin
        if (mon_on && rst_n) begin
            check("cs_low_cycles", 32'((($time - t_fall) / TCK)), FL);
            check("sclk_rises", 32'(sclk_rises - rise_base), N);
        end
    end

    // Reference: a frame ends FL cycles after cs_n falls; then load or drop.
    int          low_cnt = 0;
    logic        m_valid = 1'b0;
    logic        m_over = 1'b0;
    logic [11:0] m_sample = '0;
    logic        fin;

    assign fin = (adc_cs_n == 1'b0) && (low_cnt == FL - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt  <= 0;
            m_valid  <= 1'b0;
            m_over   <= 1'b0;
            m_sample <= '0;
        end else begin
            m_over <= 1'b0;
            if (adc_cs_n == 1'b0) low_cnt <= fin ? 0 : low_cnt + 1;
            if (fin && (!m_valid || sample_ready)) begin
                m_sample <= cur_word[11:0];
                m_valid  <= 1'b1;
            end else if (fin) begin
                m_over <= 1'b1;
            end else if (m_valid && sample_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on)
            check("model", 32'({sample_valid, overrun, sample}),
                  32'({m_valid, m_over, m_sample}));
    end

    initial begin
        // mode: 0 ready low, 1 ready high, 2 ready only on completion edge
        tbl[0] = '{12'hA5C, 0, 12'hA5C, 1'b1, 1'b0};
        tbl[1] = '{12'h3C3, 0, 12'hA5C, 1'b1, 1'b1};
        tbl[2] = '{12'h0FF, 2, 12'h0FF, 1'b1, 1'b0};
        tbl[3] = '{12'h800, 0, 12'h0FF, 1'b1, 1'b1};
        tbl[4] = '{12'h123, 1, 12'h123, 1'b1, 1'b0};
        tbl[5] = '{12'hFFF, 0, 12'hFFF, 1'b1, 1'b0};
        tbl[6] = '{12'h555, 0, 12'hFFF, 1'b1, 1'b1};

        #1 rst_n = 1'b0;
        en = 1'b1;
        #1 mon_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_hold",
                  32'({adc_cs_n, adc_sclk, sample_valid, overrun, sample}),
                  32'h0000_C000);
        end
        en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_cs_high", 32'({adc_cs_n, adc_sclk}), 32'h3);

        word_q.push_back(16'h0A5C);
        sample_ready = 1'b1;
        falls0 = n_falls;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_cs(1'b0, 1'b0);
        wait_cs(1'b1, 1'b0);
        check("single_sample", 32'(sample), 32'hA5C);
        check("single_valid", 32'(sample_valid), 32'h1);
        repeat (200) @(negedge clk);
        check("single_one_frame", 32'(n_falls - falls0), 32'h1);

        check_period = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            word_q.push_back({4'($urandom), tbl[i].data});
            wait_cs(1'b0, 1'b0);
            if (tbl[i].mode == 2) begin
                sample_ready = 1'b0;
                repeat (FL - 1) @(negedge clk);
                sample_ready = 1'b1;
            end else begin
                sample_ready = (tbl[i].mode == 1);
            end
            wait_cs(1'b1, 1'b0);
            check($sformatf("vec%0d_sample", i), 32'(sample),
                  32'(tbl[i].exp_sample));
            check($sformatf("vec%0d_valid", i), 32'(sample_valid),
                  32'(tbl[i].exp_valid));
            check($sformatf("vec%0d_overrun", i), 32'(overrun),
                  32'(tbl[i].exp_ovr));
            if (tbl[i].mode == 2) sample_ready = 1'b0;
        end
        en = 1'b0;
        check_period = 1'b0;
        repeat (100) @(negedge clk);
        check("bp_valid_held", 32'(sample_valid), 32'h1);
        check("bp_sample_held", 32'(sample), 32'hFFF);
        sample_ready = 1'b1;
        @(negedge clk);
        check("ready_drops_valid", 32'(sample_valid), 32'h0);
        sample_ready = 1'b0;

        word_q.push_back(16'hF9E1);
        falls0 = n_falls;
        en = 1'b1;
        wait_cs(1'b0, 1'b0);
        wait_rises(7);
        en = 1'b0;
        wait_cs(1'b1, 1'b0);
        check("endrop_sample", 32'(sample), 32'h9E1);
        check("endrop_valid", 32'(sample_valid), 32'h1);
        repeat (150) @(negedge clk);
        check("endrop_frames", 32'(n_falls - falls0), 32'h1);
        check("endrop_idle_cs", 32'(adc_cs_n), 32'h1);

        sample_ready = 1'b1;
        check_period = 1'b1;
        for (int i = 0; i < 4; i++)
            word_q.push_back({4'($urandom), (i % 2 != 0) ? 12'hFFF : 12'h000});
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cs(1'b0, 1'b0);
            wait_cs(1'b1, 1'b0);
            check("alt_sample", 32'(sample), (i % 2 != 0) ? 32'hFFF : 32'h0);
            check("alt_overrun", 32'(overrun), 32'h0);
        end

        for (int i = 0; i < 8; i++) begin
            word_q.push_back(16'($urandom));
            wait_cs(1'b0, 1'b1);
            wait_cs(1'b1, 1'b1);
        end

        sample_ready = 1'b1;
        check_period = 1'b0;
        word_q.push_back(16'h1234);
        wait_cs(1'b0, 1'b0);
        wait_rises(9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pins", 32'({adc_cs_n, adc_sclk}), 32'h3);
        check("async_reset_valid", 32'(sample_valid), 32'h0);
        repeat (3) @(negedge clk);
        word_q.push_back(16'h7C3A);
        rst_n = 1'b1;
        wait_cs(1'b0, 1'b0);
        wait_cs(1'b1, 1'b0);
        check("post_reset_sample", 32'(sample), 32'hC3A);
        check("post_reset_valid", 32'(sample_valid), 32'h1);
        en = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
